// File: rtl/wb_arbiter_2x1_if.sv
// Wishbone B4 bus bundle shared by the arbiter's master and slave ports.
// The master modport drives the request; the slave modport drives the response.
interface wb_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            cyc;
    logic            stb;
    logic            we;
    logic [AW-1:0]   adr;
    logic [DW-1:0]   dat_w;
    logic [DW/8-1:0] sel;
    logic [2:0]      cti;
    logic [1:0]      bte;
    logic            ack;
    logic            err;
    logic [DW-1:0]   dat_r;

    modport master (
        output cyc, stb, we, adr, dat_w, sel, cti, bte,
        input  ack, err, dat_r
    );

    modport slave (
        input  cyc, stb, we, adr, dat_w, sel, cti, bte,
        output ack, err, dat_r
    );
endinterface

// File: rtl/wb_arbiter_2x1.sv
// Two-master round-robin Wishbone arbiter with a stalled-cycle watchdog.
// The grant is held for a whole CYC; a stuck slave is aborted with ERR.
module wb_arbiter_2x1 #(
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic       clk,
    input  logic       rst,
    wb_if.slave        m0,
    wb_if.slave        m1,
    wb_if.master       s0,
    output logic [1:0] gnt,
    output logic       timeout
);

    localparam int SW    = WB_DATA_WIDTH / 8;
    localparam int WDT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit WDT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [WDT_W-1:0] WDT_MAX = WDT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_ABORT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               first_q, first_d;
    logic [WDT_W-1:0]   wdt_q, wdt_d;

    logic                     o_cyc;
    logic                     o_stb;
    logic                     o_we;
    logic [WB_ADDR_WIDTH-1:0] o_adr;
    logic [WB_DATA_WIDTH-1:0] o_dat_w;
    logic [SW-1:0]            o_sel;
    logic [2:0]               o_cti;
    logic [1:0]               o_bte;
    logic                     stalled;
    logic                     fire;

    assign o_cyc   = owner_q ? m1.cyc   : m0.cyc;
    assign o_stb   = owner_q ? m1.stb   : m0.stb;
    assign o_we    = owner_q ? m1.we    : m0.we;
    assign o_adr   = owner_q ? m1.adr   : m0.adr;
    assign o_dat_w = owner_q ? m1.dat_w : m0.dat_w;
    assign o_sel   = owner_q ? m1.sel   : m0.sel;
    assign o_cti   = owner_q ? m1.cti   : m0.cti;
    assign o_bte   = owner_q ? m1.bte   : m0.bte;

    // A beat is stalled while the owner strobes and the slave has not answered;
    // a response on the threshold cycle wins over the abort.
    assign stalled = o_stb && !s0.ack && !s0.err;
    assign fire    = WDT_EN && stalled && (wdt_q == WDT_MAX);

    // State register; last resets to 1 so m0 wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            first_q <= 1'b0;
            wdt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            first_q <= first_d;
            wdt_q   <= wdt_d;
        end
    end

    // Next-state: grant selection, release, and watchdog counting.
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        first_d = 1'b0;
        wdt_d   = wdt_q;
        case (state_q)
            S_IDLE: begin
                wdt_d = '0;
                if (m0.cyc || m1.cyc) begin
                    state_d = S_BUSY;
                    if (m0.cyc && m1.cyc) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = m1.cyc;
                    end
                    last_d = owner_d;
                end
            end
            S_BUSY: begin
                if (fire) begin
                    state_d = S_ABORT;
                    first_d = 1'b1;
                    wdt_d   = '0;
                end else begin
                    if (!o_cyc) begin
                        state_d = S_IDLE;
                    end
                    if (!stalled) begin
                        wdt_d = '0;
                    end else if (wdt_q != '1) begin
                        wdt_d = wdt_q + 1'b1;
                    end
                end
            end
            S_ABORT: begin
                wdt_d = '0;
                if (!o_cyc) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: owner routed to s0 in BUSY, everything else held at zero.
    always_comb begin
        s0.cyc   = 1'b0;
        s0.stb   = 1'b0;
        s0.we    = 1'b0;
        s0.adr   = '0;
        s0.dat_w = '0;
        s0.sel   = '0;
        s0.cti   = '0;
        s0.bte   = '0;
        m0.ack   = 1'b0;
        m0.err   = 1'b0;
        m0.dat_r = '0;
        m1.ack   = 1'b0;
        m1.err   = 1'b0;
        m1.dat_r = '0;
        gnt      = 2'b00;
        timeout  = 1'b0;
        case (state_q)
            S_BUSY: begin
                gnt      = owner_q ? 2'b10 : 2'b01;
                s0.cyc   = o_cyc;
                s0.stb   = o_stb;
                s0.we    = o_we;
                s0.adr   = o_adr;
                s0.dat_w = o_dat_w;
                s0.sel   = o_sel;
                s0.cti   = o_cti;
                s0.bte   = o_bte;
                if (owner_q) begin
                    m1.ack   = s0.ack;
                    m1.err   = s0.err;
                    m1.dat_r = s0.dat_r;
                end else begin
                    m0.ack   = s0.ack;
                    m0.err   = s0.err;
                    m0.dat_r = s0.dat_r;
                end
            end
            S_ABORT: begin
                gnt     = owner_q ? 2'b10 : 2'b01;
                timeout = first_q;
                if (owner_q) begin
                    m1.err = first_q;
                end else begin
                    m0.err = first_q;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_arbiter_2x1.sv
// Bench for wb_arbiter_2x1: directed timing cases plus randomized rounds
// checked by a scoreboard fed from a round-robin transaction model.
module tb_wb_arbiter_2x1;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] gnt;
    logic       timeout;

    always #5 clk = ~clk;

    wb_if #(.AW(32), .DW(32)) m0_if ();
    wb_if #(.AW(32), .DW(32)) m1_if ();
    wb_if #(.AW(32), .DW(32)) s0_if ();

    wb_arbiter_2x1 #(
        .WB_ADDR_WIDTH (32),
        .WB_DATA_WIDTH (32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m0     (m0_if),
        .m1     (m1_if),
        .s0     (s0_if),
        .gnt    (gnt),
        .timeout(timeout)
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Slave side: manual drive for directed cases, random-latency responder otherwise.
    logic        sl_auto = 1'b0;
    logic        man_ack = 1'b0;
    logic        man_err = 1'b0;
    logic [31:0] man_dat = 32'h0;
    logic        a_ack   = 1'b0;
    logic [31:0] a_dat   = 32'h0;
    int          a_cnt   = 0;

    assign s0_if.ack   = sl_auto ? a_ack : man_ack;
    assign s0_if.err   = man_err;
    assign s0_if.dat_r = sl_auto ? a_dat : man_dat;

    function automatic logic [31:0] rdata(logic [31:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    always begin
        @(posedge clk);
        #2;
        if (sl_auto && s0_if.cyc && s0_if.stb) begin
            if (a_cnt == 0) begin
                a_ack = 1'b1;
                a_dat = rdata(s0_if.adr);
                a_cnt = $urandom_range(0, 3);
            end else begin
                a_ack = 1'b0;
                a_dat = 32'h0;
                a_cnt--;
            end
        end else begin
            a_ack = 1'b0;
            a_dat = 32'h0;
        end
    end

    task automatic mdrv(int id, logic cyc, logic stb, logic we,
                        logic [31:0] adr, logic [31:0] dat, logic [2:0] cti);
        if (id == 0) begin
            m0_if.cyc   = cyc;
            m0_if.stb   = stb;
            m0_if.we    = we;
            m0_if.adr   = adr;
            m0_if.dat_w = dat;
            m0_if.sel   = stb ? 4'hF : 4'h0;
            m0_if.cti   = cti;
            m0_if.bte   = 2'b00;
        end else begin
            m1_if.cyc   = cyc;
            m1_if.stb   = stb;
            m1_if.we    = we;
            m1_if.adr   = adr;
            m1_if.dat_w = dat;
            m1_if.sel   = stb ? 4'hF : 4'h0;
            m1_if.cti   = cti;
            m1_if.bte   = 2'b00;
        end
    endtask

    function automatic logic m_ack(int id);
        return (id == 0) ? m0_if.ack : m1_if.ack;
    endfunction

    function automatic logic [31:0] beat_dat(int id, int i, logic [31:0] seed);
        return seed ^ (32'(i) * 32'h0101_0101) ^ (32'(id) << 28);
    endfunction

    function automatic logic [2:0] cti_of(int n, int i);
        if (n == 1) return 3'b000;
        return (i == n - 1) ? 3'b111 : 3'b010;
    endfunction

    // Scoreboard: every acknowledged beat on s0 must match the next expected beat.
    typedef struct {
        int          id;
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [2:0]  cti;
    } beat_t;

    beat_t exp_q[$];
    bit    sb_en = 1'b0;

    always @(negedge clk) begin
        beat_t e;
        if (sb_en && s0_if.cyc && s0_if.stb && s0_if.ack) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_beat", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("sb_gnt", gnt, 64'(2'b01 << e.id));
                chk("sb_adr", s0_if.adr, e.adr);
                chk("sb_we", s0_if.we, e.we);
                chk("sb_cti", s0_if.cti, e.cti);
                if (e.we) begin
                    chk("sb_wdat", s0_if.dat_w, e.dat);
                end else begin
                    chk("sb_rdat", (e.id == 1) ? m1_if.dat_r : m0_if.dat_r, rdata(e.adr));
                end
                chk("sb_own_ack", (e.id == 1) ? m1_if.ack : m0_if.ack, 64'd1);
                chk("sb_oth_ack", (e.id == 1) ? m0_if.ack : m1_if.ack, 64'd0);
                chk("sb_oth_dat", (e.id == 1) ? m0_if.dat_r : m1_if.dat_r, 64'd0);
            end
        end
    end

    int to_cnt  = 0;
    int err_cnt = 0;

    always @(negedge clk) begin
        if (timeout) to_cnt++;
        if (m0_if.err || m1_if.err) err_cnt++;
    end

    task automatic m_burst(int id, int n, logic [31:0] base, logic we, logic [31:0] seed);
        int b;
        for (int i = 0; i < n; i++) begin
            mdrv(id, 1'b1, 1'b1, we, base + 32'(4 * i), beat_dat(id, i, seed), cti_of(n, i));
            b = 0;
            do begin
                @(negedge clk);
                b++;
            end while (!m_ack(id) && b < 200);
            if (b >= 200) chk("bfm_ack_wait", 64'd0, 64'd1);
            @(posedge clk);
            #1;
        end
        mdrv(id, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic push(int id, int n, logic [31:0] base, logic we, logic [31:0] seed);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.id  = id;
            e.adr = base + 32'(4 * i);
            e.dat = beat_dat(id, i, seed);
            e.we  = we;
            e.cti = cti_of(n, i);
            exp_q.push_back(e);
        end
    endtask

    // Reference arbitration: simultaneous requests go to the master not granted last.
    int last_m = 1;

    task automatic round();
        int          req;
        int          first;
        int          n    [2];
        logic [31:0] base [2];
        logic        we   [2];
        logic [31:0] seed [2];
        req = $urandom_range(1, 3);
        for (int id = 0; id < 2; id++) begin
            n[id]    = $urandom_range(1, 4);
            base[id] = $urandom & 32'hFFFF_FFF0;
            we[id]   = 1'($urandom_range(0, 1));
            seed[id] = $urandom;
        end
        if (req == 3) first = 1 - last_m;
        else first = (req == 1) ? 0 : 1;
        push(first, n[first], base[first], we[first], seed[first]);
        if (req == 3) begin
            push(1 - first, n[1 - first], base[1 - first], we[1 - first], seed[1 - first]);
            last_m = 1 - first;
        end else begin
            last_m = first;
        end
        fork
            begin
                if (req[0]) m_burst(0, n[0], base[0], we[0], seed[0]);
            end
            begin
                if (req[1]) m_burst(1, n[1], base[1], we[1], seed[1]);
            end
        join
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic wait_gnt(string nm, logic [1:0] g, int budget);
        int b;
        b = 0;
        while (gnt !== g && b < budget) begin
            @(negedge clk);
            b++;
        end
        chk(nm, gnt, g);
    endtask

    // Acknowledge one beat from the negedge, release at the next drive point.
    task automatic man_beat();
        man_ack = 1'b1;
        @(posedge clk);
        #1;
        man_ack = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1);
    end

    initial begin
        int to0;
        int e0;
        rst = 1'b1;
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        mdrv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_gnt", gnt, 64'd0);
        chk("rst_timeout", timeout, 64'd0);
        chk("rst_s0_cyc", s0_if.cyc, 64'd0);
        chk("rst_s0_stb", s0_if.stb, 64'd0);
        chk("rst_s0_adr", s0_if.adr, 64'd0);
        chk("rst_m0_ack", m0_if.ack, 64'd0);
        chk("rst_m1_err", m1_if.err, 64'd0);

        // m0 single write
        @(posedge clk);
        #1;
        mdrv(0, 1'b1, 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 3'b000);
        @(negedge clk);
        chk("wr_s0_cyc_pre", s0_if.cyc, 64'd0);
        @(negedge clk);
        chk("wr_gnt", gnt, 64'b01);
        chk("wr_s0_cyc", s0_if.cyc, 64'd1);
        chk("wr_s0_adr", s0_if.adr, 64'h1000);
        chk("wr_s0_dat", s0_if.dat_w, 64'hDEADBEEF);
        chk("wr_s0_we", s0_if.we, 64'd1);
        chk("wr_s0_sel", s0_if.sel, 64'hF);
        man_ack = 1'b1;
        #1;
        chk("wr_m0_ack", m0_if.ack, 64'd1);
        chk("wr_m1_ack", m1_if.ack, 64'd0);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        chk("wr_release_cycle_gnt", gnt, 64'b01);
        @(negedge clk);
        chk("wr_idle_gnt", gnt, 64'b00);
        chk("wr_idle_s0_cyc", s0_if.cyc, 64'd0);

        // contention right after reset: m0 first, one idle cycle, then m1
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdrv(0, 1'b1, 1'b1, 1'b0, 32'h2000, 32'h0, 3'b000);
        mdrv(1, 1'b1, 1'b1, 1'b0, 32'h3000, 32'h0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("rr_first_m0", gnt, 64'b01);
        man_dat = 32'h1234_5678;
        man_ack = 1'b1;
        #1;
        chk("rr_m0_dat", m0_if.dat_r, 64'h1234_5678);
        chk("rr_m1_ack_blocked", m1_if.ack, 64'd0);
        chk("rr_m1_dat_blocked", m1_if.dat_r, 64'd0);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        man_dat = 32'h0;
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        chk("rr_release_gnt", gnt, 64'b01);
        @(negedge clk);
        chk("rr_gap_gnt", gnt, 64'b00);
        @(negedge clk);
        chk("rr_second_m1", gnt, 64'b10);
        chk("rr_second_adr", s0_if.adr, 64'h3000);
        man_beat();
        mdrv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) @(negedge clk);

        // m0 alone leaves last=0, so the next contention goes to m1
        @(posedge clk);
        #1;
        mdrv(0, 1'b1, 1'b1, 1'b0, 32'h2100, 32'h0, 3'b000);
        @(negedge clk);
        wait_gnt("rr_solo_m0", 2'b01, 4);
        man_beat();
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        mdrv(0, 1'b1, 1'b1, 1'b0, 32'h2200, 32'h0, 3'b000);
        mdrv(1, 1'b1, 1'b1, 1'b0, 32'h3200, 32'h0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("rr_last0_m1_first", gnt, 64'b10);
        man_beat();
        mdrv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        wait_gnt("rr_last0_m0_next", 2'b01, 4);
        man_beat();
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) @(negedge clk);

        // watchdog abort after TO stalled cycles
        @(posedge clk);
        #1;
        to0 = to_cnt;
        e0  = err_cnt;
        mdrv(0, 1'b1, 1'b1, 1'b0, 32'h4000, 32'h0, 3'b000);
        @(negedge clk);
        repeat (TO) @(negedge clk);
        chk("wdt_last_stall_cyc", s0_if.cyc, 64'd1);
        chk("wdt_no_early_timeout", 64'(to_cnt - to0), 64'd0);
        @(negedge clk);
        chk("abort_s0_cyc", s0_if.cyc, 64'd0);
        chk("abort_m0_err", m0_if.err, 64'd1);
        chk("abort_m1_err", m1_if.err, 64'd0);
        chk("abort_timeout", timeout, 64'd1);
        repeat (3) @(negedge clk);
        chk("abort_hold_s0_cyc", s0_if.cyc, 64'd0);
        @(posedge clk);
        #1;
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("abort_exit_gnt", gnt, 64'b00);
        chk("abort_timeout_pulses", 64'(to_cnt - to0), 64'd1);
        chk("abort_err_pulses", 64'(err_cnt - e0), 64'd1);

        // ACK on stalled cycle 7, then ACK exactly on the threshold cycle
        @(posedge clk);
        #1;
        to0 = to_cnt;
        e0  = err_cnt;
        mdrv(0, 1'b1, 1'b1, 1'b1, 32'h5000, 32'hCAFE_F00D, 3'b000);
        @(negedge clk);
        repeat (7) @(negedge clk);
        chk("late7_s0_cyc", s0_if.cyc, 64'd1);
        man_beat();
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        mdrv(0, 1'b1, 1'b1, 1'b0, 32'h5004, 32'h0, 3'b000);
        @(negedge clk);
        repeat (TO) @(negedge clk);
        chk("late8_s0_cyc", s0_if.cyc, 64'd1);
        man_ack = 1'b1;
        #1;
        chk("late8_m0_ack", m0_if.ack, 64'd1);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(negedge clk);
        chk("late8_still_busy", gnt, 64'b01);
        @(negedge clk);
        chk("late8_idle", gnt, 64'b00);
        chk("late_no_timeout", 64'(to_cnt - to0), 64'd0);
        chk("late_no_err", 64'(err_cnt - e0), 64'd0);

        // reset in the middle of an m1 burst
        @(posedge clk);
        #1;
        mdrv(1, 1'b1, 1'b1, 1'b0, 32'h6000, 32'h0, 3'b010);
        @(negedge clk);
        wait_gnt("mid_m1_gnt", 2'b10, 4);
        man_beat();
        mdrv(1, 1'b1, 1'b1, 1'b0, 32'h6004, 32'h0, 3'b010);
        @(negedge clk);
        chk("mid_m1_hold", gnt, 64'b10);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mdrv(0, 1'b1, 1'b1, 1'b0, 32'h7000, 32'h0, 3'b000);
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_gnt", gnt, 64'b00);
        chk("mid_rst_s0_cyc", s0_if.cyc, 64'd0);
        man_ack = 1'b1;
        #1;
        chk("mid_rst_no_ack", m1_if.ack, 64'd0);
        @(posedge clk);
        #1;
        man_ack = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_rst_m0_first", gnt, 64'b01);
        @(posedge clk);
        #1;
        mdrv(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        mdrv(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (3) @(negedge clk);

        // randomized rounds against the transaction model
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        last_m  = 1;
        sl_auto = 1'b1;
        sb_en   = 1'b1;
        to0     = to_cnt;
        for (int r = 0; r < 40; r++) begin
            round();
        end
        sb_en = 1'b0;
        chk("sb_drained", exp_q.size(), 64'd0);
        chk("rand_no_timeout", 64'(to_cnt - to0), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
